mem_wb_stage: RTL

MEM/WB pipeline stage of the five-stage MIPS core: sits directly downstream of the data memory and consumes its word read data. Each cycle it captures the MEM-stage results (ALU result, raw memory word, PC, destination register, control), selects and sign/zero-extends the loaded byte/halfword/word, and holds the resulting write-back value and register-file write controls in registers for the WB stage. It supports pipeline hold and bubble insertion, and optionally flags misaligned loads.

---
 rtl/mem_wb_stage_if.sv | 30 +++
 rtl/mem_wb_stage.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-stage results and stall controls in, WB-stage register contents out.
// The master side is the upstream pipeline (or a bench); the slave side is mem_wb_stage.
interface mem_wb_stage_if;
    logic        hold;
    logic        flush;
    logic [31:0] pc_m;
    logic [31:0] alu_m;
    logic [31:0] mem_m;
    logic [2:0]  load_type_m;
    logic [1:0]  wd_sel_m;
    logic [4:0]  wr_reg_m;
    logic        reg_write_m;

    logic [31:0] pc_w;
    logic [31:0] wd_w;
    logic [4:0]  wr_reg_w;
    logic        reg_write_w;
    logic        valid_w;
    logic        adel_w;

    modport master (
        output hold, flush, pc_m, alu_m, mem_m, load_type_m, wd_sel_m, wr_reg_m, reg_write_m,
        input  pc_w, wd_w, wr_reg_w, reg_write_w, valid_w, adel_w
    );

    modport slave (
        input  hold, flush, pc_m, alu_m, mem_m, load_type_m, wd_sel_m, wr_reg_m, reg_write_m,
        output pc_w, wd_w, wr_reg_w, reg_write_w, valid_w, adel_w
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: forms load data from the raw memory word and registers WB controls.
// Define MEM_WB_ALIGN_CHECK_EN to flag misaligned LW/LH/LHU loads on adel_w.
module mem_wb_stage (
    input logic           clk,
    input logic           reset,
    mem_wb_stage_if.slave bus
);

    localparam logic [2:0] LtLbu = 3'd1;
    localparam logic [2:0] LtLb  = 3'd2;
    localparam logic [2:0] LtLhu = 3'd3;
    localparam logic [2:0] LtLh  = 3'd4;

    localparam logic [1:0] SelLoad = 2'd1;
    localparam logic [1:0] SelLink = 2'd2;

    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] loadData;
    logic [31:0] wdNext;
    logic        regWriteNext;
    logic        misaligned;

    logic [31:0] pcQ;
    logic [31:0] wdQ;
    logic [4:0]  wrRegQ;
    logic        regWriteQ;
    logic        validQ;
    logic        adelQ;

    // Byte lane and halfword selection from the word-aligned memory read.
    always_comb begin
        byteVal = 8'h00;
        unique case (bus.alu_m[1:0])
            2'd0: byteVal = bus.mem_m[7:0];
            2'd1: byteVal = bus.mem_m[15:8];
            2'd2: byteVal = bus.mem_m[23:16];
            2'd3: byteVal = bus.mem_m[31:24];
            default: byteVal = 8'h00;
        endcase
        halfVal = bus.alu_m[1] ? bus.mem_m[31:16] : bus.mem_m[15:0];
    end

    always_comb begin
        loadData = bus.mem_m;
        case (bus.load_type_m)
            LtLbu:   loadData = {24'h000000, byteVal};
            LtLb:    loadData = {{24{byteVal[7]}}, byteVal};
            LtLhu:   loadData = {16'h0000, halfVal};
            LtLh:    loadData = {{16{halfVal[15]}}, halfVal};
            default: loadData = bus.mem_m;
        endcase
    end

    always_comb begin
        wdNext = bus.alu_m;
        case (bus.wd_sel_m)
            SelLoad: wdNext = loadData;
            SelLink: wdNext = bus.pc_m + 32'd8;
            default: wdNext = bus.alu_m;
        endcase
    end

`ifdef MEM_WB_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        if (bus.wd_sel_m == SelLoad) begin
            case (bus.load_type_m)
                LtLbu, LtLb: misaligned = 1'b0;
                LtLhu, LtLh: misaligned = bus.alu_m[0];
                default:     misaligned = (bus.alu_m[1:0] != 2'd0);
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // Writes to $zero and faulting loads never reach the register file.
    assign regWriteNext = bus.reg_write_m && (bus.wr_reg_m != 5'd0) && !misaligned;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            pcQ       <= 32'h0;
            wdQ       <= 32'h0;
            wrRegQ    <= 5'd0;
            regWriteQ <= 1'b0;
            validQ    <= 1'b0;
            adelQ     <= 1'b0;
        end else if (!bus.hold) begin
            pcQ       <= bus.pc_m;
            wdQ       <= wdNext;
            wrRegQ    <= bus.wr_reg_m;
            regWriteQ <= regWriteNext;
            validQ    <= 1'b1;
            adelQ     <= misaligned;
        end
    end

    assign bus.pc_w        = pcQ;
    assign bus.wd_w        = wdQ;
    assign bus.wr_reg_w    = wrRegQ;
    assign bus.reg_write_w = regWriteQ;
    assign bus.valid_w     = validQ;
    assign bus.adel_w      = adelQ;

endmodule
